// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
//   Multi-digit BCD up/down counter stepped by rising edges of a slow
//   toggle level (tick_level), detected in the clk_in domain. A small
//   IDLE/RUN/HOLD state machine gates stepping. Supports clear, parallel
//   load (digits above 9 saturate to 9) and a one-cycle terminal-count pulse
//   on wrap-around.
//
// Ports
//   clk_in      system clock, rising edge
//   rst         asynchronous active-high reset
//   tick_level  divided toggle level; each 0->1 is one count step
//   start       enter RUN (from IDLE/HOLD)
//   stop        enter HOLD from RUN (beats start)
//   clear       count to zero, enter IDLE (beats everything)
//   up_down     1 = up, 0 = down, sampled at each step
//   load        load saturated load_value into count
//   load_value  BCD value to load
//   count       registered BCD count
//   running     high while in RUN
//   tc_pulse    one-cycle pulse aligned with a wrapped count

// One BCD digit of the increment/decrement chain. cin requests a +/-1 on
// this digit; cout propagates the carry (up) or borrow (down).
module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q    = 4'd9;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_tick_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    tick_level,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    tc_pulse
);
  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           tick_d;
  logic           step;
  logic           do_step;
  logic [W-1:0]   count_nxt;
  logic [W-1:0]   load_sat;
  logic [NUM_DIGITS:0] carry;

  // tick_d resets high so a level already high at reset release is not a step
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) tick_d <= 1'b1;
    else     tick_d <= tick_level;
  end

  assign step = tick_level & ~tick_d;

  // Step only from RUN as seen at the start of the cycle, and only when no
  // higher-priority control is present.
  assign do_step = step & (state_q == RUN) & ~clear & ~load & ~stop;

  // Ripple carry/borrow chain; the least significant digit always gets +/-1,
  // carry out of the top digit marks the wrap.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d    (count[4*g +: 4]),
      .up   (up_down),
      .cin  (carry[g]),
      .q    (count_nxt[4*g +: 4]),
      .cout (carry[g+1])
    );
    assign load_sat[4*g +: 4] = (load_value[4*g +: 4] > 4'd9) ? 4'd9 : load_value[4*g +: 4];
  end

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: clear > stop > start. load leaves the state alone.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (start) begin
      state_d = RUN;
    end
  end

  // Outputs decoded from the state register only
  always_comb begin
    running = (state_q == RUN);
  end

  // Count and terminal-count pulse
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_sat;
      end else if (do_step) begin
        count    <= count_nxt;
        tc_pulse <= carry[NUM_DIGITS];
      end
    end
  end
endmodule

// File: tb/tb_bcd_tick_counter.sv
module tb_bcd_tick_counter;
  localparam int ND  = 4;
  localparam int MAX = 10000;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          tick_level = 1'b0;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [15:0]   load_value = '0;
  logic [15:0]   count;
  logic          running, tc_pulse;

  int checks = 0;
  int errors = 0;
  int tc_cnt = 0;
  bit cmp_en = 1'b0;

  bcd_tick_counter #(.NUM_DIGITS(ND)) dut (
    .clk_in(clk_in), .rst(rst), .tick_level(tick_level), .start(start),
    .stop(stop), .clear(clear), .up_down(up_down), .load(load),
    .load_value(load_value), .count(count), .running(running), .tc_pulse(tc_pulse)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  int m_val;    // count as an integer 0..MAX-1
  int m_state;  // 0 idle, 1 run, 2 hold
  bit m_tick_d;
  bit m_tc;

  function automatic int sat_to_int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < ND; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_val = 0; m_state = 0; m_tick_d = 1'b1; m_tc = 1'b0;
    end else begin
      bit edge_seen;
      bit was_run;
      edge_seen = tick_level && !m_tick_d;
      m_tick_d  = tick_level;
      m_tc      = 1'b0;
      was_run   = (m_state == 1);
      if (clear) begin
        m_val = 0; m_state = 0;
      end else begin
        if (load) m_val = sat_to_int(load_value);
        else if (was_run && edge_seen && !stop) begin
          if (up_down) begin
            m_val = m_val + 1;
            if (m_val == MAX) begin m_val = 0; m_tc = 1'b1; end
          end else begin
            if (m_val == 0) begin m_val = MAX - 1; m_tc = 1'b1; end
            else m_val = m_val - 1;
          end
        end
        if (stop) begin
          if (was_run) m_state = 2;
        end else if (start) m_state = 1;
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge
  always @(negedge clk_in) begin
    if (tc_pulse) tc_cnt++;
    if (cmp_en) begin
      checks++;
      if (count !== to_bcd(m_val) || running !== (m_state == 1) || tc_pulse !== m_tc) begin
        errors++;
        $display("FAIL model t=%0t count=%h/%h running=%b/%b tc=%b/%b", $time,
                 count, to_bcd(m_val), running, (m_state == 1), tc_pulse, m_tc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(negedge clk_in); #1;
  endtask

  task automatic tick();
    tick_level = 1'b1; cyc(); cyc();
    tick_level = 1'b0; cyc(); cyc();
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    int hold;
    // Reset state
    #2; chk("reset_count", count, 16'h0000);
    chk("reset_running", {15'd0, running}, 16'd0);
    chk("reset_tc", {15'd0, tc_pulse}, 16'd0);
    cyc(); rst = 1'b0; cmp_en = 1'b1; cyc();

    // 1: start, 12 up ticks
    tc_cnt = 0;
    up_down = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    repeat (12) tick();
    chk("t1_count", count, 16'h0012);
    chk("t1_running", {15'd0, running}, 16'd1);
    chk("t1_no_tc", 16'(tc_cnt), 16'd0);

    // 2: load 9998, two ticks, wrap with tc
    load_value = 16'h9998; load = 1'b1; cyc(); load = 1'b0;
    tick();
    chk("t2_9999", count, 16'h9999);
    tick_level = 1'b1; cyc();
    chk("t2_wrap", count, 16'h0000);
    chk("t2_tc_hi", {15'd0, tc_pulse}, 16'd1);
    cyc();
    chk("t2_tc_lo", {15'd0, tc_pulse}, 16'd0);
    tick_level = 1'b0; cyc(); cyc();

    // 3: count down from 0000, then saturating load
    up_down = 1'b0;
    tick_level = 1'b1; cyc();
    chk("t3_down_wrap", count, 16'h9999);
    chk("t3_tc", {15'd0, tc_pulse}, 16'd1);
    cyc(); tick_level = 1'b0; cyc(); cyc();
    load_value = 16'hA5F3; load = 1'b1; cyc(); load = 1'b0;
    chk("t3_sat_load", count, 16'h9593);

    // 4: stop freezes, start resumes by exactly one
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t4_held", {15'd0, running}, 16'd0);
    repeat (5) tick();
    chk("t4_frozen", count, 16'h9593);
    up_down = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    tick();
    chk("t4_resume", count, 16'h9594);

    // 5: simultaneous events
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("t5_stop_wins", {15'd0, running}, 16'd0);
    start = 1'b1; cyc(); start = 1'b0;
    load_value = 16'h0042; load = 1'b1; tick_level = 1'b1; cyc(); load = 1'b0;
    cyc(); tick_level = 1'b0; cyc(); cyc();
    chk("t5_load_beats_step", count, 16'h0042);
    clear = 1'b1; load = 1'b1; load_value = 16'h1234; cyc(); clear = 1'b0; load = 1'b0;
    chk("t5_clear_count", count, 16'h0000);
    chk("t5_clear_idle", {15'd0, running}, 16'd0);

    // 6: tick high through reset release, then asynchronous mid-run reset
    tick_level = 1'b1; rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; cyc(); cyc();
    chk("t6_no_step", count, 16'h0000);
    tick_level = 1'b0;
    load_value = 16'h0357; load = 1'b1; cyc(); load = 1'b0;
    chk("t6_loaded", count, 16'h0357);
    #2 rst = 1'b1; #1;
    chk("t6_async_count", count, 16'h0000);
    chk("t6_async_run", {15'd0, running}, 16'd0);
    cyc(); rst = 1'b0; cyc();

    // Random phase against the model
    hold = 1;
    for (int i = 0; i < 4000; i++) begin
      hold--;
      if (hold <= 0) begin tick_level = ~tick_level; hold = int'($urandom_range(1, 4)); end
      clear      = ($urandom_range(0, 99) < 3);
      load       = ($urandom_range(0, 99) < 5);
      stop       = ($urandom_range(0, 99) < 5);
      start      = ($urandom_range(0, 99) < 12);
      up_down    = ($urandom_range(0, 99) < 60);
      load_value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_value = (load_value & 16'h0F0F) | 16'h9090;
      rst        = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
